// File: rtl/fib_pkg.sv
// fib_pkg: shared width default and checker state encoding.
package fib_pkg;
  localparam int W_DEF = 32;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
endpackage

// File: rtl/fib_gen_core.sv
// fib_gen_core: two-register Fibonacci generator; cur is the golden term for the current index.
module fib_gen_core import fib_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         advance,
  output logic [W-1:0] cur
);
  logic [W-1:0] nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= '0;
      nxt <= '0;
    end else if (clear) begin
      cur <= '0;
      nxt <= {{(W-1){1'b0}}, 1'b1};
    end else if (advance) begin
      cur <= nxt;
      nxt <= cur + nxt;
    end
  end
endmodule

// File: rtl/fib_seq_checker.sv
// fib_seq_checker: compares a streamed sequence of len terms against the Fibonacci series mod 2^W.
module fib_seq_checker import fib_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] len,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         err_valid,
  output logic [W-1:0] err_index,
  output logic [W-1:0] err_expected,
  output logic [W-1:0] match_count,
  output logic [W-1:0] err_count
);
  state_t       state, state_n;
  logic [W-1:0] len_r, idx, idx_inc, cur;
  logic         start_ok, accept, hit, last;
  assign in_ready = state == RUN;
  assign busy     = state != IDLE;
  assign done     = state == FIN;
  assign start_ok = start && state == IDLE;
  assign accept   = in_valid && in_ready;
  assign hit      = in_data == cur;
  assign idx_inc  = idx + 1'b1;
  assign last     = accept && idx_inc == len_r;
  fib_gen_core #(.W(W)) u_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_ok),
    .advance (accept),
    .cur     (cur)
  );
  always_comb begin
    state_n = state;
    state_n = start_ok ? (len == '0 ? FIN : RUN) :
              last           ? FIN  :
              (state == FIN) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      len_r        <= '0;
      idx          <= '0;
      pass         <= 1'b0;
      err_valid    <= 1'b0;
      err_index    <= '0;
      err_expected <= '0;
      match_count  <= '0;
      err_count    <= '0;
    end else begin
      state     <= state_n;
      err_valid <= accept && !hit;
      if (start_ok) begin
        len_r        <= len;
        idx          <= '0;
        pass         <= len == '0;
        err_index    <= '0;
        err_expected <= '0;
        match_count  <= '0;
        err_count    <= '0;
      end else if (accept) begin
        idx <= idx_inc;
        if (hit) match_count <= match_count + 1'b1;
        else begin
          err_count    <= err_count + 1'b1;
          err_index    <= idx;
          err_expected <= cur;
        end
        // pass must reflect the final beat, which is not yet in err_count
        if (last) pass <= err_count == '0 && hit;
      end
    end
  end
endmodule

// File: tb/tb_fib_seq_checker.sv
// tb_fib_seq_checker: randomized self-checking bench against a Fibonacci reference model.
module tb_fib_seq_checker;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic start = 0, in_valid = 0;
  logic [31:0] len = 0, in_data = 0;
  logic in_ready, busy, done, pass, err_valid;
  logic [31:0] err_index, err_expected, match_count, err_count;
  logic start8 = 0, in_valid8 = 0;
  logic [7:0] len8 = 0, in_data8 = 0;
  logic in_ready8, busy8, done8, pass8, err_valid8;
  logic [7:0] err_index8, err_expected8, match_count8, err_count8;
  int total = 0, bad = 0, done_seen = 0, err8_seen = 0;
  logic [31:0] beats[$];
  int exp_idx_q[$];
  logic [31:0] exp_val_q[$];

  fib_seq_checker dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .done(done), .pass(pass), .err_valid(err_valid),
    .err_index(err_index), .err_expected(err_expected), .match_count(match_count), .err_count(err_count)
  );
  fib_seq_checker #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .len(len8), .in_valid(in_valid8), .in_data(in_data8),
    .in_ready(in_ready8), .busy(busy8), .done(done8), .pass(pass8), .err_valid(err_valid8),
    .err_index(err_index8), .err_expected(err_expected8), .match_count(match_count8), .err_count(err_count8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fib(input int n);
    logic [31:0] a = 0, b = 1, t;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  always @(negedge clk) begin
    if (done) done_seen++;
    if (err_valid8) err8_seen++;
    if (err_valid) begin
      if (exp_idx_q.size() == 0) chk("err_extra", 1, 0);
      else begin
        chk("err_index", err_index, exp_idx_q.pop_front());
        chk("err_expected", err_expected, exp_val_q.pop_front());
      end
    end
  end

  task automatic run(input int n, input int gap_max, input bit toggle);
    int em = 0, last_err = 0, gap;
    for (int i = 0; i < n; i++)
      if (beats[i] !== fib(i)) begin
        exp_idx_q.push_back(i);
        exp_val_q.push_back(fib(i));
        em++;
        last_err = i;
      end
    @(negedge clk);
    start = 1;
    len = n;
    @(negedge clk);
    start = 0;
    len = $urandom;
    if (n == 0) begin
      chk("len0_done", done, 1);
      chk("len0_pass", pass, 1);
      chk("len0_ready", in_ready, 0);
    end else begin
      chk("run_busy", busy, 1);
      chk("run_pass_clr", pass, 0);
      chk("run_mc_clr", match_count, 0);
      chk("run_ec_clr", err_count, 0);
      for (int i = 0; i < n; i++) begin
        gap = toggle ? (i > 0 ? 1 : 0) : $urandom_range(0, gap_max);
        repeat (gap) begin
          in_valid = 0;
          in_data = $urandom;
          start = $urandom_range(0, 3) == 0;
          len = $urandom;
          @(negedge clk);
        end
        in_valid = 1;
        in_data = beats[i];
        start = $urandom_range(0, 3) == 0;
        @(negedge clk);
      end
      in_valid = 0;
      start = 0;
      chk("run_done", done, 1);
      chk("run_pass", pass, em == 0);
      chk("run_match_count", match_count, n - em);
      chk("run_err_count", err_count, em);
      chk("run_ready_fin", in_ready, 0);
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("pass_hold", pass, em == 0);
    chk("err_pending", exp_idx_q.size(), 0);
    if (em > 0) chk("err_index_hold", err_index, last_err);
  endtask

  initial begin
    int n, d0;
    logic [7:0] f8;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_pass", pass, 0);
    chk("rst_counts", {match_count, err_count}, 0);
    rst = 0;
    in_valid = 1;
    repeat (3) @(negedge clk);
    in_valid = 0;
    chk("idle_ignore_busy", busy, 0);
    chk("idle_ignore_mc", match_count, 0);
    beats = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    run(10, 0, 0);
    beats = '{0, 1, 1, 2, 4, 5};
    run(6, 0, 0);
    chk("mm_err_index", err_index, 4);
    chk("mm_err_expected", err_expected, 3);
    beats = {};
    run(0, 0, 0);
    beats = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    run(10, 0, 1);
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(0, 40);
      beats = {};
      for (int i = 0; i < n; i++)
        beats.push_back($urandom_range(0, 4) == 0 ? fib(i) ^ (32'd1 << $urandom_range(0, 31)) : fib(i));
      run(n, 2, 0);
    end
    @(negedge clk);
    start = 1;
    len = 5;
    @(negedge clk);
    start = 0;
    beats = '{0, 1, 1};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      in_data = beats[i];
      @(negedge clk);
    end
    chk("pre_rst_mc", match_count, 3);
    d0 = done_seen;
    rst = 1;
    start = 1;
    len = 2;
    in_valid = 1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_outs", {done, pass, err_valid}, 0);
    chk("abort_err", {err_index, err_expected}, 0);
    chk("abort_counts", {match_count, err_count}, 0);
    rst = 0;
    start = 0;
    in_valid = 0;
    @(negedge clk);
    chk("abort_idle", busy, 0);
    chk("abort_no_done", done_seen, d0);
    run(3, 0, 0);
    @(negedge clk);
    start8 = 1;
    len8 = 15;
    @(negedge clk);
    start8 = 0;
    for (int i = 0; i < 15; i++) begin
      f8 = fib(i) % 256;
      in_valid8 = 1;
      in_data8 = f8;
      @(negedge clk);
    end
    in_valid8 = 0;
    chk("w8_done", done8, 1);
    chk("w8_pass", pass8, 1);
    chk("w8_match_count", match_count8, 15);
    chk("w8_err_count", err_count8, 0);
    chk("w8_no_err_valid", err8_seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
